// File: rtl/a2d_sched_pkg.sv
// a2d_sched shared types and default timing.
// Optional stats outputs are enabled with A2D_SCHED_STATS_EN.
package a2d_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_CONV,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CH_LFT   = 2'd0,
        CH_RGHT  = 2'd1,
        CH_STEER = 2'd2,
        CH_BATT  = 2'd3
    } chan_e;

    localparam int unsigned DEF_PERIOD   = 1048576;
    localparam int unsigned DEF_CONV_CYC = 1100;
    localparam int unsigned DEF_NUM_CH   = 4;

endpackage

// File: rtl/a2d_sched_tmr.sv
// Up-counter 0..TERM-1 with clear, enable and terminal-count flag.
// tc is high in the cycle the count sits at TERM-1 while enabled.
module a2d_sched_tmr #(
    parameter int unsigned TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = (TERM > 1) ? $clog2(TERM) : 1;

    logic [W-1:0] cnt;

    assign tc = en && (cnt == W'(TERM - 1));

    // count while enabled, wrap at terminal count, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: merges auto-sample timer and client requests into nxt slots.
// Define A2D_SCHED_STATS_EN to add conv_cnt / ovr_cnt outputs.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned CONV_CYC = DEF_CONV_CYC,
    parameter int unsigned NUM_CH   = DEF_NUM_CH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req,
    output logic       req_ack,
    output logic       nxt,
    output logic       busy,
    output logic       smpl_vld,
    output logic [1:0] smpl_chan,
    output logic [3:0] fresh,
    input  logic       clr_fresh,
    output logic       overrun
`ifdef A2D_SCHED_STATS_EN
    ,
    output logic [15:0] conv_cnt,
    output logic [7:0]  ovr_cnt
`endif
);

    state_e state, state_n;

    logic per_tc;
    logic per_hit;
    logic conv_tc;
    logic pend_auto;
    logic pend_req;
    logic ack_owed;
    logic take;
    logic ovr_evt;

    a2d_sched_tmr #(.TERM(PERIOD)) u_per (
        .clk (clk),
        .rst (rst),
        .clr (~en),
        .en  (en),
        .tc  (per_tc)
    );

    a2d_sched_tmr #(.TERM(CONV_CYC)) u_conv (
        .clk (clk),
        .rst (rst),
        .clr (state == ISSUE),
        .en  (state == WAIT_CONV),
        .tc  (conv_tc)
    );

    assign take    = (state == IDLE) && en && (pend_auto || pend_req);
    assign ovr_evt = en && per_hit && pend_auto;

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (take) state_n = ISSUE;
            ISSUE:     state_n = WAIT_CONV;
            WAIT_CONV: if (conv_tc) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // state register and flopped strobes so nxt never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            nxt      <= 1'b0;
            busy     <= 1'b0;
            smpl_vld <= 1'b0;
            req_ack  <= 1'b0;
            ack_owed <= 1'b0;
        end else begin
            state    <= state_n;
            nxt      <= (state_n == ISSUE);
            busy     <= (state_n != IDLE);
            smpl_vld <= (state_n == DONE);
            req_ack  <= (state_n == DONE) && ack_owed;
            if (take) ack_owed <= pend_req;
        end
    end

    // pending work; new triggers win over the clear on take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_hit   <= 1'b0;
            pend_auto <= 1'b0;
            pend_req  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            per_hit <= per_tc;
            if (!en) begin
                pend_auto <= 1'b0;
                pend_req  <= 1'b0;
            end else begin
                if (per_hit)   pend_auto <= 1'b1;
                else if (take) pend_auto <= 1'b0;
                if (req)       pend_req <= 1'b1;
                else if (take) pend_req <= 1'b0;
            end
            if (ovr_evt) overrun <= 1'b1;
        end
    end

    // round-robin channel tracking and freshness flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smpl_chan <= CH_BATT;
            fresh     <= 4'h0;
        end else begin
            if (state == ISSUE) begin
                if (smpl_chan == 2'(NUM_CH - 1)) smpl_chan <= CH_LFT;
                else smpl_chan <= smpl_chan + 2'd1;
            end
            if (clr_fresh) fresh <= 4'h0;
            else if (state_n == DONE) fresh[smpl_chan] <= 1'b1;
        end
    end

`ifdef A2D_SCHED_STATS_EN
    // saturating conversion and overrun counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt <= '0;
            ovr_cnt  <= '0;
        end else begin
            if (state_n == DONE && conv_cnt != 16'hFFFF)
                conv_cnt <= conv_cnt + 16'd1;
            if (ovr_evt && ovr_cnt != 8'hFF)
                ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`endif

endmodule
